// File: rtl/acc_engine.sv
// Accumulator engine: sums a block of data-memory words and writes the result
// to the word just past the block, with a four-phase request/done handshake to the CPU.
module acc_engine #(
    parameter int AW = 6,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          accbypass,
    input  logic [AW-1:0] startaddr,
    input  logic [AW-1:0] datasize,
    output logic          accdone,
    output logic          busy,
    output logic [AW-1:0] memaddr,
    output logic          memrd,
    input  logic [DW-1:0] memrdata,
    output logic          memwe,
    output logic [DW-1:0] memwdata
);

    localparam logic [AW-1:0] ONE = AW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_start;
    logic [AW-1:0] r_size;
    logic [AW-1:0] r_cnt;
    logic [DW-1:0] r_acc;
    logic          r_rd_d;
    logic          w_accept;
    logic          w_last;

    assign w_last = (r_cnt == (r_size - ONE));

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        accdone  = 1'b0;
        busy     = 1'b1;
        memrd    = 1'b0;
        memwe    = 1'b0;
        memaddr  = '0;
        memwdata = '0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (accbypass) begin
                    w_accept = 1'b1;
                    w_next   = (datasize != '0) ? S_READ : S_WRITE;
                end
            end
            S_READ: begin
                memrd   = 1'b1;
                memaddr = r_start + r_cnt;
                if (w_last) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                w_next = S_WRITE;
            end
            S_WRITE: begin
                memwe    = 1'b1;
                memaddr  = r_start + r_size;
                memwdata = r_acc;
                w_next   = S_DONE;
            end
            S_DONE: begin
                accdone = 1'b1;
                if (!accbypass) w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Read data arrives one cycle after its strobe, so accumulation follows the
    // delayed strobe; the DRAIN cycle exists to absorb the final word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_start <= '0;
            r_size  <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_rd_d  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_rd_d  <= memrd;
            if (w_accept) begin
                r_start <= startaddr;
                r_size  <= datasize;
                r_cnt   <= '0;
                r_acc   <= '0;
            end else begin
                if (memrd)  r_cnt <= r_cnt + ONE;
                if (r_rd_d) r_acc <= r_acc + memrdata;
            end
        end
    end

endmodule

// File: tb/tb_acc_engine.sv
// Scoreboard bench for acc_engine: jobs push expected reads/writes into queues,
// a negedge monitor pops and compares whatever the engine drives onto the memory bus.
module tb_acc_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        accbypass;
    logic [5:0]  startaddr;
    logic [5:0]  datasize;
    logic        accdone;
    logic        busy;
    logic [5:0]  memaddr;
    logic        memrd;
    logic [31:0] memrdata;
    logic        memwe;
    logic [31:0] memwdata;

    acc_engine #(.AW(6), .DW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .accbypass (accbypass),
        .startaddr (startaddr),
        .datasize  (datasize),
        .accdone   (accdone),
        .busy      (busy),
        .memaddr   (memaddr),
        .memrd     (memrd),
        .memrdata  (memrdata),
        .memwe     (memwe),
        .memwdata  (memwdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
        int          cyc;
    } ent_t;

    ent_t        rq[$];
    ent_t        wq[$];
    ent_t        e;
    logic [31:0] mem [0:63];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Non-read cycles return junk so any stray accumulation corrupts the sum
    always @(posedge clk) memrdata <= memrd ? mem[memaddr] : 32'hDEAD_BEEF;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (memrd && memwe) chk("rd_we_overlap", 32'(memwe), 32'd0);
            if (memrd) begin
                if (rq.size() == 0) chk("unexpected_read", 32'(memaddr), 32'hFFFF_FFFF);
                else begin
                    e = rq.pop_front();
                    chk("rd_addr", 32'(memaddr), 32'(e.addr));
                    chk("rd_cycle", cyc, e.cyc);
                end
            end
            if (memwe) begin
                if (wq.size() == 0) chk("unexpected_write", 32'(memaddr), 32'hFFFF_FFFF);
                else begin
                    e = wq.pop_front();
                    chk("wr_addr", 32'(memaddr), 32'(e.addr));
                    chk("wr_data", memwdata, e.data);
                    chk("wr_cycle", cyc, e.cyc);
                end
            end
            if (!memrd && !memwe) begin
                chk("quiet_addr", 32'(memaddr), 32'd0);
                chk("quiet_wdata", memwdata, 32'd0);
            end
        end
    end

    // Issue one job and push its expected reads/write; then follow the handshake.
    task automatic run_job(input logic [5:0] st, input logic [5:0] n, input logic [31:0] sum,
                           input int hold, input bit scramble);
        int         a;
        int         lim;
        logic [5:0] ad;
        @(negedge clk);
        accbypass = 1'b1;
        startaddr = st;
        datasize  = n;
        a = cyc + 1;
        for (int i = 0; i < int'(n); i++) begin
            ad = st + 6'(i);
            rq.push_back('{addr: ad, data: 32'd0, cyc: a + i});
        end
        ad = st + n;
        wq.push_back('{addr: ad, data: sum, cyc: (n != 0) ? a + int'(n) + 1 : a});
        @(negedge clk);
        if (scramble) begin
            startaddr = ~st;
            datasize  = 6'd7;
        end
        lim = 0;
        while (!accdone && lim < 200) begin
            @(negedge clk);
            lim++;
        end
        chk("accdone_cycle", cyc, (n != 0) ? a + int'(n) + 2 : a + 1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("accdone_hold", 32'(accdone), 32'd1);
            chk("busy_hold", 32'(busy), 32'd1);
        end
        accbypass = 1'b0;
        @(negedge clk);
        chk("accdone_drop", 32'(accdone), 32'd0);
        chk("busy_drop", 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        for (int i = 0; i < 64; i++) mem[i] = 32'h100 + 32'(i);
        reset     = 1'b1;
        accbypass = 1'b0;
        startaddr = '0;
        datasize  = '0;
        repeat (3) @(negedge clk);
        chk("rst_accdone", 32'(accdone), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_memrd", 32'(memrd), 32'd0);
        chk("rst_memwe", 32'(memwe), 32'd0);
        chk("rst_memaddr", 32'(memaddr), 32'd0);
        chk("rst_memwdata", memwdata, 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Basic block sum, with accbypass held through DONE for 5 cycles
        mem[4] = 32'd1; mem[5] = 32'd2; mem[6] = 32'd3; mem[7] = 32'd4;
        run_job(6'd4, 6'd4, 32'd10, 5, 1'b0);

        // Address wrap 63 -> 0, inputs changed mid-job
        mem[62] = 32'd5; mem[63] = 32'd6; mem[0] = 32'd7;
        run_job(6'd62, 6'd3, 32'd18, 0, 1'b1);

        // Empty job
        run_job(6'd9, 6'd0, 32'd0, 0, 1'b0);

        // Sum wraps modulo 2^32
        mem[0] = 32'hFFFF_FFFF; mem[1] = 32'h0000_0002;
        run_job(6'd0, 6'd2, 32'h0000_0001, 1, 1'b0);

        // Reset during the second read: two reads, no write
        mem[20] = 32'h11; mem[21] = 32'h22; mem[22] = 32'h33; mem[23] = 32'h44;
        @(negedge clk);
        accbypass = 1'b1;
        startaddr = 6'd20;
        datasize  = 6'd4;
        a = cyc + 1;
        rq.push_back('{addr: 6'd20, data: 32'd0, cyc: a});
        rq.push_back('{addr: 6'd21, data: 32'd0, cyc: a + 1});
        @(negedge clk);
        @(negedge clk);
        reset     = 1'b1;
        accbypass = 1'b0;
        @(negedge clk);
        chk("abort_memrd", 32'(memrd), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_accdone", 32'(accdone), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_idle_busy", 32'(busy), 32'd0);

        mem[0] = 32'h0000_1234;
        run_job(6'd0, 6'd1, 32'h0000_1234, 0, 1'b0);

        repeat (3) @(negedge clk);
        chk("rdq_drained", rq.size(), 32'd0);
        chk("wrq_drained", wq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/acc_engine.md
ACC_ENGINE -- requirements
Module: acc_engine

Interface
REQ-001 SHALL have parameter AW, default 6: data-memory word-address width, matching the startaddr/datasize fields.
REQ-002 SHALL have parameter DW, default 32: data-memory word width.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port accbypass, input, 1: level request from the CPU; high means "run job".
REQ-006 SHALL have port startaddr, input, AW: first word address of the job; sampled only on job accept.
REQ-007 SHALL have port datasize, input, AW: word count N, 0..63; sampled only on job accept.
REQ-008 SHALL have port accdone, output, 1: completion flag back to the CPU.
REQ-009 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-010 SHALL have port memaddr, output, AW: data-memory word address.
REQ-011 SHALL have port memrd, output, 1: read strobe; the memory returns data on memrdata in the next cycle.
REQ-012 SHALL have port memrdata, input, DW: read data.
REQ-013 SHALL have port memwe, output, 1: write strobe.
REQ-014 SHALL have port memwdata, output, DW: write data.

Function
REQ-015 SHALL implement the states IDLE, READ, DRAIN, WRITE and DONE.
REQ-016 Job: sum of N words starting at startaddr, modulo 2^DW; result written to address (startaddr+N) mod 2^AW.
REQ-017 Accept: in IDLE with accbypass=1 at edge T, SHALL latch startaddr, datasize and clear the accumulator; next state is READ if N>0, else WRITE.
REQ-018 READ: SHALL occupy cycles T+1..T+N, with memrd=1 and memaddr=(start+i) mod 2^AW for i=0..N-1, and exactly one read per cycle.
REQ-019 SHALL add memrdata to the accumulator at every edge following a cycle with memrd=1; no other data SHALL be accumulated.
REQ-020 DRAIN: one cycle (T+N+1) in which the last word is accumulated, with memrd=0; next state is WRITE.
REQ-021 WRITE: one cycle with memwe=1, memaddr=(start+N) mod 2^AW and memwdata=accumulator; next state is DONE.
REQ-022 DONE: accdone=1 held while accbypass=1; on an edge with accbypass=0, SHALL go to IDLE and accdone=0 in the following cycle (four-phase handshake).
REQ-023 Latency: for N>0, the WRITE cycle is T+N+2 and accdone first rises at T+N+3; for N=0, WRITE is T+1 and accdone rises at T+2.
REQ-024 SHALL ignore accbypass and the startaddr/datasize inputs in READ, DRAIN and WRITE; an input change during a job SHALL NOT alter it.
REQ-025 SHALL NOT accept a new job until IDLE has been re-entered; accbypass held high through DONE SHALL NOT restart the engine.
REQ-026 Address wrap: read and write addresses wrap modulo 2^AW (63 -> 0); the sum wraps modulo 2^DW with no overflow flag.
REQ-027 memrd and memwe SHALL never be high in the same cycle; outside READ and WRITE both SHALL be 0 and memaddr SHALL be 0.
REQ-028 memwdata SHALL be 0 in every cycle other than WRITE.

Reset
REQ-029 reset=1 at an edge SHALL force IDLE and zero the accumulator and latched fields, with accdone=0, busy=0, memrd=0, memwe=0, memaddr=0 and memwdata=0 in the next cycle.
REQ-030 Reset SHALL override every state including mid-READ and WRITE; an aborted job SHALL perform no write after reset is seen.
REQ-031 After reset deasserts, accbypass=1 in IDLE SHALL start a fresh job with no residue from the aborted one.

Verification
REQ-032 Memory[4..7]={1,2,3,4}; start=4, N=4; accbypass=1 -> four reads at addresses 4..7, write 10 to address 8 at T+6, accdone=1 at T+7 until accbypass drops.
REQ-033 start=62, N=3, memory[62,63,0]={5,6,7} -> reads at 62, 63 and 0; write 18 to address 1.
REQ-034 N=0, start=9 -> no reads; write 0 to address 9 at T+1; accdone at T+2.
REQ-035 Words 0xFFFFFFFF and 0x00000002 at addresses 0..1, N=2 -> write 0x00000001 to address 2.
REQ-036 Reset asserted in the second READ cycle -> memrd=0 and busy=0 the next cycle, no memwe ever; a following job start=0, N=1 completes correctly.
REQ-037 Hold accbypass high for 5 cycles after accdone -> accdone stays 1 with no new reads; drop accbypass -> IDLE, accdone=0 one cycle later.
